// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I core pipeline control logic.
package rv32_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } pipe_state_t;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID instruction and a load in EX.
module hazard_detect
    import rv32_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // A load writing x0 never creates a dependency, so it is excluded.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use = ex_mem_read && (ex_rd != X0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble decisions for the
// 5-stage core, data-memory wait FSM with timeout, and saturating
// performance counters.
module pipe_ctrl
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_pc_src,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  bubble_mem_wb,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    pipe_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic timeout;
    logic freeze;
    logic branch_flush;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Prioritised stall/flush decision: reset, memory freeze, branch, load-use.
    always_comb begin
        timeout       = (state_q == WAIT_MEM) && (wcnt_q == WCNT_MAX);
        freeze        = mem_req && !mem_ready && !timeout;
        branch_flush  = 1'b0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_mem_wb = 1'b0;
        if (rst) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (freeze) begin
            // IF/ID/EX contents are held, so branch and load-use are
            // simply re-evaluated once the access releases.
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            stall_ex_mem  = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (ex_pc_src) begin
            // The ID instruction is wrong-path, so a load-use on it is moot.
            branch_flush = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    // Memory-wait FSM next state and counter updates.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_err_d   = 1'b0;
        stall_cnt_d = stall_pc ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = branch_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = WAIT_MEM;
                    wcnt_d  = WCNT_W'(1);
                end else begin
                    wcnt_d  = '0;
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (timeout) begin
                    // Forced release: the MEM instruction advances with
                    // undefined data and the error is flagged next cycle.
                    state_d   = RUN;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // State, wait counter, error pulse and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expected
// outputs per cycle, the monitor pops and compares them mid-cycle.
module tb_pipe_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Packed control order: stall_pc, stall_if_id, stall_id_ex,
    // stall_ex_mem, flush_if_id, flush_id_ex, bubble_mem_wb.
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0000110;
    localparam logic [6:0] C_FRZ  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    typedef struct {
        logic [6:0]       ctl;
        logic             err;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_pc_src;
    logic             mem_req, mem_ready;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic             flush_if_id, flush_id_ex, bubble_mem_wb, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_pc_src     (ex_pc_src),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .stall_pc      (stall_pc),
        .stall_if_id   (stall_if_id),
        .stall_id_ex   (stall_id_ex),
        .stall_ex_mem  (stall_ex_mem),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .bubble_mem_wb (bubble_mem_wb),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    // Apply one cycle of inputs just after the edge and queue what that
    // cycle must show.
    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic pc, input logic mq, input logic my,
                         input logic [6:0] ectl, input logic eerr,
                         input logic [CNT_W-1:0] esc, input logic [CNT_W-1:0] efe,
                         input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_pc_src = pc; mem_req = mq; mem_ready = my;
        e.ctl = ectl; e.err = eerr; e.sc = esc; e.fe = efe; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [CNT_W-1:0] esc, input logic [CNT_W-1:0] efe,
                        input logic eerr, input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, eerr, esc, efe, tag);
    endtask

    // Monitor: the controller presents a decision every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e = exp_q.pop_front();
            got = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                   flush_if_id, flush_id_ex, bubble_mem_wb};
            n_cmp++;
            if (got !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctrl got %b want %b", e.tag, got, e.ctl);
            end
            n_cmp++;
            if (mem_err !== e.err) begin
                n_bad++;
                $display("FAIL %s mem_err got %b want %b", e.tag, mem_err, e.err);
            end
            n_cmp++;
            if (stall_cycles !== e.sc || flush_events !== e.fe) begin
                n_bad++;
                $display("FAIL %s counters got sc=%0d fe=%0d want sc=%0d fe=%0d",
                         e.tag, stall_cycles, flush_events, e.sc, e.fe);
            end
        end
    end

    initial begin
        rst = 1'b1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_pc_src = 0; mem_req = 0; mem_ready = 0;
        repeat (2) @(posedge clk);

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0, "reset");
        // Load-use through rs2, then ex_rd=x0 gives no hazard
        drive(0, 1, 5, 0, 1, 5, 1, 0, 0, 0, C_LU, 0, 0, 0, "load_use");
        idle(1, 0, 0, "after_lu");
        drive(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, C_NONE, 0, 1, 0, "lu_x0");
        drive(0, 5, 2, 1, 0, 5, 1, 0, 0, 0, C_LU, 0, 1, 0, "load_use_rs1");
        // Branch together with load-use: branch wins, no stall count
        drive(0, 1, 5, 0, 1, 5, 1, 1, 0, 0, C_BR, 0, 2, 0, "branch_lu");
        idle(2, 1, 0, "after_br");
        // Memory wait of 3 cycles; a branch during the freeze is ignored
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 1, "wait1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 1, "wait2");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0, 4, 1, "wait3_branch");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 5, 1, "wait_release");
        // Zero-wait access causes no stall
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 5, 1, "zero_wait");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 5, 1, "reset2");
        // Timeout: 4 freeze cycles, 5th advances, mem_err pulses next
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0, "to_1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0, "to_2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 0, "to_3");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 0, "to_4");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 4, 0, "to_release");
        idle(4, 0, 1, "to_err");
        idle(4, 0, 0, "to_err_clear");
        // Reset in the 2nd wait cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 4, 0, "rw_1");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 5, 0, "rw_rst");
        idle(0, 0, 0, "rw_after");
        // wcnt restarted: a fresh wait again needs 4 freeze cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0, "rw_to1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0, "rw_to2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 0, "rw_to3");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 0, "rw_to4");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0, 4, 0, "rw_ready");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 4, 0, "reset3");
        // Saturation: 20 load-use cycles, stall_cycles holds at 15
        for (int i = 0; i < 20; i++)
            drive(0, 0, 7, 0, 1, 7, 1, 0, 0, 0, C_LU, 0,
                  CNT_W'((i > 15) ? 15 : i), 0, "sat");
        idle(15, 0, 0, "sat_hold");

        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain queue left %0d want 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
